// File: rtl/branch_pc_unit.sv
// Fetch-stage PC register with branch/jump redirect and a one-deep redirect hold during stalls.
// Redirect latency 1 cycle when unstalled; a stalled redirect is applied on the first unstalled edge.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [31:0]      br_pc_plus4,
    input  logic [31:0]      br_offset_sh,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             flush,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic             err_misalign
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]  state;
    logic [31:0] pend_tgt;
    logic        br_redirect;
    logic        redirect_req;
    logic [31:0] br_target;
    logic [31:0] req_target;
    logic [31:0] load_tgt;

    // The branch is older than the jump in ID, so it wins and the jump is squashed.
    assign br_redirect  = br_valid & br_taken;
    assign redirect_req = br_redirect | jmp_valid;
    assign br_target    = br_pc_plus4 + br_offset_sh;
    assign req_target   = br_redirect ? br_target : jmp_target;
    assign load_tgt     = {req_target[31:2], 2'b00};

    assign flush            = redirect_req;
    assign pc_plus4         = pc + 32'd4;
    assign redirect_pending = (state == HOLD);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc           <= {RESET_PC[31:2], 2'b00};
            state        <= RUN;
            pend_tgt     <= 32'h0;
            redirect_cnt <= '0;
            err_misalign <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_req) begin
                        if (stall) begin
                            pend_tgt <= load_tgt;
                            state    <= HOLD;
                        end else begin
                            pc <= load_tgt;
                        end
                    end else if (!stall) begin
                        pc <= pc_plus4;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        if (redirect_req) begin
                            pend_tgt <= load_tgt;
                        end
                    end else begin
                        // A fresh redirect is younger than the held one and supersedes it.
                        pc    <= redirect_req ? load_tgt : pend_tgt;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            if (redirect_req && (redirect_cnt != {CNT_W{1'b1}})) begin
                redirect_cnt <= redirect_cnt + 1'b1;
            end
            if (redirect_req && (req_target[1:0] != 2'b00)) begin
                err_misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: one task per scenario, inline checks against hand-computed values.
module tb_branch_pc_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_pc_plus4;
    logic [31:0] br_offset_sh;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        redirect_pending;
    logic [15:0] redirect_cnt;
    logic        err_misalign;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    branch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall),
        .br_valid(br_valid), .br_taken(br_taken),
        .br_pc_plus4(br_pc_plus4), .br_offset_sh(br_offset_sh),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .pc(pc), .pc_plus4(pc_plus4), .flush(flush),
        .redirect_pending(redirect_pending), .redirect_cnt(redirect_cnt),
        .err_misalign(err_misalign)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_req();
        br_valid = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
        br_pc_plus4 = 32'h0; br_offset_sh = 32'h0; jmp_target = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; clear_req();
        step(); step();
        tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        tests_run++; if (redirect_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_cnt: got %h want 0", redirect_cnt); end
        tests_run++; if (redirect_pending !== 1'b0) begin tests_failed++; $display("FAIL reset_pending: got %b want 0", redirect_pending); end
        tests_run++; if (err_misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err_misalign); end
        tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %b want 0", flush); end
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++; if (pc !== 32'(4 * i)) begin tests_failed++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(4 * i)); end
        end
        tests_run++; if (pc_plus4 !== 32'd16) begin tests_failed++; $display("FAIL seq_pc_plus4: got %h want %h", pc_plus4, 32'd16); end
        tests_run++; if (redirect_cnt !== 16'h0) begin tests_failed++; $display("FAIL seq_cnt: got %h want 0", redirect_cnt); end
    endtask

    task automatic test_branch();
        // pc is 0xC; 13 sequential steps reach 0x40
        for (int i = 0; i < 13; i++) step();
        tests_run++; if (pc !== 32'h40) begin tests_failed++; $display("FAIL br_start_pc: got %h want %h", pc, 32'h40); end
        br_valid = 1'b1; br_taken = 1'b1; br_pc_plus4 = 32'h44; br_offset_sh = 32'hFFFF_FFF0;
        #1;
        tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL br_flush: got %b want 1", flush); end
        step();
        clear_req();
        #1;
        tests_run++; if (pc !== 32'h34) begin tests_failed++; $display("FAIL br_pc: got %h want %h", pc, 32'h34); end
        tests_run++; if (redirect_cnt !== 16'd1) begin tests_failed++; $display("FAIL br_cnt: got %0d want 1", redirect_cnt); end
        tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL br_flush_drop: got %b want 0", flush); end
    endtask

    task automatic test_stall_hold();
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h200;
        #1;
        tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL hold_flush: got %b want 1", flush); end
        step();
        clear_req();
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (pc !== 32'h34) begin tests_failed++; $display("FAIL hold_pc%0d: got %h want %h", i, pc, 32'h34); end
            tests_run++; if (redirect_pending !== 1'b1) begin tests_failed++; $display("FAIL hold_pending%0d: got %b want 1", i, redirect_pending); end
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        tests_run++; if (pc !== 32'h200) begin tests_failed++; $display("FAIL hold_release_pc: got %h want %h", pc, 32'h200); end
        tests_run++; if (redirect_pending !== 1'b0) begin tests_failed++; $display("FAIL hold_release_pending: got %b want 0", redirect_pending); end
        tests_run++; if (redirect_cnt !== 16'd2) begin tests_failed++; $display("FAIL hold_cnt: got %0d want 2", redirect_cnt); end
    endtask

    task automatic test_back_to_back_priority();
        br_valid = 1'b1; br_taken = 1'b1; br_pc_plus4 = 32'hF0; br_offset_sh = 32'h10;
        jmp_valid = 1'b1; jmp_target = 32'h300;
        step();
        clear_req();
        tests_run++; if (pc !== 32'h100) begin tests_failed++; $display("FAIL prio_pc: got %h want %h", pc, 32'h100); end
        tests_run++; if (redirect_cnt !== 16'd3) begin tests_failed++; $display("FAIL prio_cnt: got %0d want 3", redirect_cnt); end
        tests_run++; if (err_misalign !== 1'b0) begin tests_failed++; $display("FAIL prio_err: got %b want 0", err_misalign); end
    endtask

    task automatic test_misalign_wrap();
        jmp_valid = 1'b1; jmp_target = 32'h203;
        step();
        clear_req();
        tests_run++; if (pc !== 32'h200) begin tests_failed++; $display("FAIL mis_pc: got %h want %h", pc, 32'h200); end
        tests_run++; if (err_misalign !== 1'b1) begin tests_failed++; $display("FAIL mis_err: got %b want 1", err_misalign); end
        jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
        step();
        clear_req();
        tests_run++; if (pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc_top: got %h want %h", pc, 32'hFFFF_FFFC); end
        tests_run++; if (pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4); end
        step();
        tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc: got %h want 0", pc); end
        tests_run++; if (err_misalign !== 1'b1) begin tests_failed++; $display("FAIL mis_sticky: got %b want 1", err_misalign); end
        tests_run++; if (redirect_cnt !== 16'd5) begin tests_failed++; $display("FAIL mis_cnt: got %0d want 5", redirect_cnt); end
    endtask

    task automatic test_hold_overwrite();
        stall = 1'b1;
        step();
        tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL run_stall_pc: got %h want 0", pc); end
        jmp_valid = 1'b1; jmp_target = 32'h500;
        step();
        jmp_target = 32'h600;
        step();
        clear_req();
        tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL ovw_pc_held: got %h want 0", pc); end
        tests_run++; if (redirect_pending !== 1'b1) begin tests_failed++; $display("FAIL ovw_pending: got %b want 1", redirect_pending); end
        stall = 1'b0;
        step();
        tests_run++; if (pc !== 32'h600) begin tests_failed++; $display("FAIL ovw_pc: got %h want %h", pc, 32'h600); end
        tests_run++; if (redirect_cnt !== 16'd7) begin tests_failed++; $display("FAIL ovw_cnt: got %0d want 7", redirect_cnt); end
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h700;
        step();
        clear_req();
        stall = 1'b0; br_valid = 1'b1; br_taken = 1'b1; br_pc_plus4 = 32'h8F0; br_offset_sh = 32'h10;
        step();
        clear_req();
        tests_run++; if (pc !== 32'h900) begin tests_failed++; $display("FAIL override_pc: got %h want %h", pc, 32'h900); end
        tests_run++; if (redirect_pending !== 1'b0) begin tests_failed++; $display("FAIL override_pending: got %b want 0", redirect_pending); end
        br_valid = 1'b1; br_taken = 1'b0; br_pc_plus4 = 32'h10; br_offset_sh = 32'h40;
        #1;
        tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL not_taken_flush: got %b want 0", flush); end
        step();
        clear_req();
        tests_run++; if (pc !== 32'h904) begin tests_failed++; $display("FAIL not_taken_pc: got %h want %h", pc, 32'h904); end
        tests_run++; if (redirect_cnt !== 16'd9) begin tests_failed++; $display("FAIL not_taken_cnt: got %0d want 9", redirect_cnt); end
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h80;
        step();
        clear_req();
        tests_run++; if (redirect_pending !== 1'b1) begin tests_failed++; $display("FAIL rh_pending: got %b want 1", redirect_pending); end
        reset_n = 1'b0;
        step();
        tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL rh_pc: got %h want 0", pc); end
        tests_run++; if (redirect_pending !== 1'b0) begin tests_failed++; $display("FAIL rh_pending_clr: got %b want 0", redirect_pending); end
        tests_run++; if (err_misalign !== 1'b0) begin tests_failed++; $display("FAIL rh_err_clr: got %b want 0", err_misalign); end
        tests_run++; if (redirect_cnt !== 16'h0) begin tests_failed++; $display("FAIL rh_cnt_clr: got %0d want 0", redirect_cnt); end
        reset_n = 1'b1; stall = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++; if (pc !== 32'(4 * i)) begin tests_failed++; $display("FAIL rh_seq%0d: got %h want %h", i, pc, 32'(4 * i)); end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_hold();
        test_back_to_back_priority();
        test_misalign_wrap();
        test_hold_overwrite();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
